// File: rtl/serial_bus_pkg.sv
// rtl/serial_bus_pkg.sv - shared types and constants for the serial bus slave ports
package serial_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_ADDR  = 3'd1,
    ST_RX_BURST = 3'd2,
    ST_RX_DATA  = 3'd3,
    ST_RD_REQ   = 3'd4
  } sip_state_e;

  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_B_READ  = 3'd3;
  localparam logic [2:0] S_B_WRITE = 3'd4;

  localparam int DEF_SLAVE_ADDR_SIZE = 12;
  localparam int DEF_WORD_SIZE       = 8;
  localparam int DEF_BURST_SIZE      = 15;

endpackage

// File: rtl/slave_in_port_if.sv
// rtl/slave_in_port_if.sv - serial master-to-slave bus bundle with master/slave views
interface slave_in_port_if;

  logic sel;
  logic addr_bus;
  logic w_data_bus;
  logic burst_size_bus;
  logic read_en;
  logic m_b_tx_valid;
  logic new_data;
  logic tx_done;
  logic split_on;
  logic s_ready;

  modport master (
    output sel, addr_bus, w_data_bus, burst_size_bus, read_en,
    output m_b_tx_valid, new_data, tx_done, split_on,
    input  s_ready
  );

  modport slave (
    input  sel, addr_bus, w_data_bus, burst_size_bus, read_en,
    input  m_b_tx_valid, new_data, tx_done, split_on,
    output s_ready
  );

endinterface

// File: rtl/sipo_shift.sv
// rtl/sipo_shift.sv - LSB-first serial-in parallel-out shifter exposing its post-shift value
module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH-1:0] q;

  // First bit received ends up in bit 0 after WIDTH shifts
  assign q_nxt = {din, q[WIDTH-1:1]};

  // Shift register; clear drops any partially received field
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/slave_in_port.sv
// rtl/slave_in_port.sv - serial bus slave receive port (optional SLAVE_IN_SPLIT_EN split abort)
module slave_in_port
  import serial_bus_pkg::*;
#(
  parameter int SLAVE_ADDR_SIZE = DEF_SLAVE_ADDR_SIZE,
  parameter int WORD_SIZE       = DEF_WORD_SIZE,
  parameter int BURST_SIZE      = DEF_BURST_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  slave_in_port_if.slave             bus,
  input  logic                       rd_ack,
  output logic                       mem_wr_en,
  output logic [SLAVE_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]       mem_wr_data,
  output logic                       rd_req,
  output logic [SLAVE_ADDR_SIZE-1:0] rd_addr,
  output logic [BURST_SIZE-1:0]      rd_len,
  output logic                       busy,
  output logic                       frame_err
);

  localparam int CNT_W = 8;

  sip_state_e state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic addr_en, burst_en, data_en, sh_clr;
  logic addr_last, burst_last, word_last, len_one, ferr_set;
  logic split_abort;
  logic [SLAVE_ADDR_SIZE-1:0] addr_nxt, base_addr, word_idx;
  logic [BURST_SIZE-1:0]      burst_nxt;
  logic [WORD_SIZE-1:0]       data_nxt;

`ifdef SLAVE_IN_SPLIT_EN
  assign split_abort = bus.split_on;
`else
  // split_on is ignored in this build
  assign split_abort = bus.split_on & 1'b0;
`endif

  sipo_shift #(.WIDTH(SLAVE_ADDR_SIZE)) u_addr_sh (
    .clk(clk), .rst(rst), .clr(sh_clr), .en(addr_en), .din(bus.addr_bus), .q_nxt(addr_nxt)
  );

  sipo_shift #(.WIDTH(BURST_SIZE)) u_burst_sh (
    .clk(clk), .rst(rst), .clr(sh_clr), .en(burst_en), .din(bus.burst_size_bus), .q_nxt(burst_nxt)
  );

  sipo_shift #(.WIDTH(WORD_SIZE)) u_data_sh (
    .clk(clk), .rst(rst), .clr(sh_clr), .en(data_en), .din(bus.w_data_bus), .q_nxt(data_nxt)
  );

  assign bus.s_ready = (state != ST_RD_REQ);
  assign busy        = (state != ST_IDLE);
  assign rd_req      = (state == ST_RD_REQ);
  assign rd_addr     = base_addr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and per-cycle control; aborts override the normal flow
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    addr_en    = 1'b0;
    burst_en   = 1'b0;
    data_en    = 1'b0;
    sh_clr     = 1'b0;
    addr_last  = 1'b0;
    burst_last = 1'b0;
    word_last  = 1'b0;
    len_one    = 1'b0;
    ferr_set   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.sel) begin
          state_d = ST_RX_ADDR;
          cnt_d   = '0;
          sh_clr  = 1'b1;
        end
      end
      ST_RX_ADDR: begin
        addr_en = 1'b1;
        cnt_d   = cnt + 1'b1;
        if (cnt == CNT_W'(SLAVE_ADDR_SIZE - 1)) begin
          addr_last = 1'b1;
          cnt_d     = '0;
          if (bus.read_en) begin
            state_d = ST_RD_REQ;
            len_one = 1'b1;
          end else if (bus.m_b_tx_valid) begin
            state_d = ST_RX_BURST;
          end else begin
            state_d = ST_RX_DATA;
          end
        end
      end
      ST_RX_BURST: begin
        burst_en = 1'b1;
        cnt_d    = cnt + 1'b1;
        if (cnt == CNT_W'(BURST_SIZE - 1)) begin
          burst_last = 1'b1;
          cnt_d      = '0;
          state_d    = ST_RD_REQ;
        end
      end
      ST_RX_DATA: begin
        data_en = 1'b1;
        cnt_d   = cnt + 1'b1;
        if (cnt == CNT_W'(WORD_SIZE - 1)) begin
          word_last = 1'b1;
          cnt_d     = '0;
          ferr_set  = !bus.new_data;
          if (bus.tx_done) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RD_REQ: begin
        if (rd_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Master released the slave mid-frame: drop the frame and flag it
    if ((state inside {ST_RX_ADDR, ST_RX_BURST, ST_RX_DATA}) && !bus.sel) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      addr_en    = 1'b0;
      burst_en   = 1'b0;
      data_en    = 1'b0;
      addr_last  = 1'b0;
      burst_last = 1'b0;
      word_last  = 1'b0;
      len_one    = 1'b0;
      sh_clr     = 1'b1;
      ferr_set   = 1'b1;
    end

    // Split abort is a legal bus event, so frame_err is left alone
    if ((state != ST_IDLE) && split_abort) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      addr_en    = 1'b0;
      burst_en   = 1'b0;
      data_en    = 1'b0;
      addr_last  = 1'b0;
      burst_last = 1'b0;
      word_last  = 1'b0;
      len_one    = 1'b0;
      sh_clr     = 1'b1;
      ferr_set   = 1'b0;
    end
  end

  // Counters, captured fields, memory write port and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      base_addr   <= '0;
      word_idx    <= '0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      rd_len      <= '0;
      frame_err   <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      mem_wr_en <= word_last;
      if (addr_last) begin
        base_addr <= addr_nxt;
      end
      if (len_one) begin
        rd_len <= BURST_SIZE'(1);
      end
      if (burst_last) begin
        rd_len <= (burst_nxt == '0) ? BURST_SIZE'(1) : burst_nxt;
      end
      if (sh_clr) begin
        word_idx <= '0;
      end else if (word_last) begin
        word_idx <= word_idx + 1'b1;
      end
      if (word_last) begin
        mem_addr    <= base_addr + word_idx;
        mem_wr_data <= data_nxt;
      end
      if (ferr_set) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_slave_in_port.sv
// tb/tb_slave_in_port.sv - directed self-checking bench for slave_in_port
module tb_slave_in_port;

  logic        clk;
  logic        rst;
  logic        rd_ack;
  logic        mem_wr_en;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wr_data;
  logic        rd_req;
  logic [11:0] rd_addr;
  logic [14:0] rd_len;
  logic        busy;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int wr_before;
  logic [7:0] w;

  slave_in_port_if bus ();

  slave_in_port #(
    .SLAVE_ADDR_SIZE(12), .WORD_SIZE(8), .BURST_SIZE(15)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .rd_ack(rd_ack),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .busy(busy), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write pulses away from the active edge
  always @(negedge clk) if (mem_wr_en) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_addr(input logic [11:0] a, input logic rd, input logic mb);
    for (int i = 0; i < 12; i++) begin
      bus.addr_bus     = a[i];
      bus.read_en      = (i == 11) ? rd : 1'b0;
      bus.m_b_tx_valid = (i == 11) ? mb : 1'b0;
      tick();
    end
    bus.read_en      = 1'b0;
    bus.m_b_tx_valid = 1'b0;
  endtask

  task automatic send_burst(input logic [14:0] b);
    for (int i = 0; i < 15; i++) begin
      bus.burst_size_bus = b[i];
      tick();
    end
    bus.burst_size_bus = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input logic nd, input logic td);
    for (int i = 0; i < 8; i++) begin
      bus.w_data_bus = d[i];
      bus.new_data   = (i == 7) ? nd : 1'b0;
      bus.tx_done    = (i == 7) ? td : 1'b0;
      tick();
    end
    bus.new_data = 1'b0;
    bus.tx_done  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_ack = 1'b0;
    bus.sel = 0; bus.addr_bus = 0; bus.w_data_bus = 0; bus.burst_size_bus = 0;
    bus.read_en = 0; bus.m_b_tx_valid = 0; bus.new_data = 0; bus.tx_done = 0; bus.split_on = 0;
    idle(2);
    check("rst_busy", busy, 0);
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_rd_req", rd_req, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_ferr", frame_err, 0);
    rst = 1'b0;
    tick();

    // Single write
    bus.sel = 1; tick();
    check("sw_busy", busy, 1);
    send_addr(12'hA5C, 0, 0);
    send_word(8'h3C, 1, 1);
    bus.sel = 0;
    check("sw_wr_en", mem_wr_en, 1);
    check("sw_addr", mem_addr, 12'hA5C);
    check("sw_data", mem_wr_data, 8'h3C);
    check("sw_idle", busy, 0);
    check("sw_ferr", frame_err, 0);
    idle(3);
    check("sw_wr_cnt", wr_cnt, 1);
    check("sw_wr_en_low", mem_wr_en, 0);

    // Burst write wrapping past the top of the address space
    bus.sel = 1; tick();
    send_addr(12'hFFE, 0, 0);
    send_word(8'h11, 1, 0);
    check("bw0_addr", mem_addr, 12'hFFE);
    check("bw0_data", mem_wr_data, 8'h11);
    send_word(8'h22, 1, 0);
    check("bw1_addr", mem_addr, 12'hFFF);
    check("bw1_data", mem_wr_data, 8'h22);
    send_word(8'h33, 1, 1);
    bus.sel = 0;
    check("bw2_addr", mem_addr, 12'h000);
    check("bw2_data", mem_wr_data, 8'h33);
    check("bw_idle", busy, 0);
    idle(3);
    check("bw_wr_cnt", wr_cnt, 4);

    // Single read, acknowledged on the fourth request cycle
    bus.sel = 1; tick();
    send_addr(12'h123, 1, 0);
    bus.sel = 0;
    check("sr_rd_req", rd_req, 1);
    check("sr_rd_addr", rd_addr, 12'h123);
    check("sr_rd_len", rd_len, 1);
    check("sr_s_ready", bus.s_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sr_hold", rd_req, 1);
    end
    rd_ack = 1; tick(); rd_ack = 0;
    check("sr_done_req", rd_req, 0);
    check("sr_done_ready", bus.s_ready, 1);
    check("sr_done_idle", busy, 0);

    // Burst read with field 5
    bus.sel = 1; tick();
    send_addr(12'h040, 0, 1);
    check("br_in_burst", rd_req, 0);
    send_burst(15'd5);
    bus.sel = 0;
    check("br_rd_req", rd_req, 1);
    check("br_rd_len", rd_len, 5);
    check("br_rd_addr", rd_addr, 12'h040);
    rd_ack = 1; tick(); rd_ack = 0;

    // Burst read with field 0 reads as length 1
    bus.sel = 1; tick();
    send_addr(12'h040, 0, 1);
    send_burst(15'd0);
    bus.sel = 0;
    check("br0_rd_len", rd_len, 1);
    rd_ack = 1; tick(); rd_ack = 0;
    check("br0_idle", busy, 0);

    // sel dropped mid-word
    wr_before = wr_cnt;
    bus.sel = 1; tick();
    send_addr(12'h200, 0, 0);
    for (int i = 0; i < 3; i++) begin
      bus.w_data_bus = 1'b1; tick();
    end
    bus.sel = 0; tick();
    check("sd_idle", busy, 0);
    check("sd_ferr", frame_err, 1);
    idle(3);
    check("sd_no_write", wr_cnt, wr_before);

    // Reset after 6 address bits
    bus.sel = 1; tick();
    for (int i = 0; i < 6; i++) begin
      bus.addr_bus = i[0]; tick();
    end
    rst = 1; tick(); rst = 0; bus.sel = 0;
    check("mr_busy", busy, 0);
    check("mr_s_ready", bus.s_ready, 1);
    check("mr_rd_req", rd_req, 0);
    check("mr_wr_en", mem_wr_en, 0);
    check("mr_mem_addr", mem_addr, 0);
    check("mr_mem_data", mem_wr_data, 0);
    check("mr_rd_addr", rd_addr, 0);
    check("mr_rd_len", rd_len, 0);
    check("mr_ferr", frame_err, 0);

    // Missing new_data still writes, but flags the frame
    bus.sel = 1; tick();
    send_addr(12'h7F0, 0, 0);
    send_word(8'hA5, 0, 1);
    bus.sel = 0;
    check("nd_wr_en", mem_wr_en, 1);
    check("nd_addr", mem_addr, 12'h7F0);
    check("nd_data", mem_wr_data, 8'hA5);
    check("nd_ferr", frame_err, 1);
    idle(2);
    rst = 1; tick(); rst = 0;
    check("nd_ferr_cleared", frame_err, 0);

    // Split pulse during RX_DATA
    wr_before = wr_cnt;
    w = 8'h5A;
    bus.sel = 1; tick();
    send_addr(12'h100, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.w_data_bus = w[i]; tick();
    end
    bus.w_data_bus = w[4]; bus.split_on = 1; tick(); bus.split_on = 0;
`ifdef SLAVE_IN_SPLIT_EN
    check("sp_idle", busy, 0);
    bus.sel = 0;
    idle(3);
    check("sp_no_write", wr_cnt, wr_before);
    check("sp_ferr", frame_err, 0);
`else
    check("sp_busy", busy, 1);
    for (int i = 5; i < 8; i++) begin
      bus.w_data_bus = w[i];
      bus.new_data   = (i == 7);
      bus.tx_done    = (i == 7);
      tick();
    end
    bus.new_data = 0; bus.tx_done = 0; bus.sel = 0;
    check("sp_wr_en", mem_wr_en, 1);
    check("sp_addr", mem_addr, 12'h100);
    check("sp_data", mem_wr_data, 8'h5A);
    idle(3);
    check("sp_wr_cnt", wr_cnt, wr_before + 1);
    check("sp_ferr", frame_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
